// File: rtl/pipelined_add_sub.sv
// Pipelined adder/subtractor: operands are captured on acceptance, then summed one
// WIDTH/STAGES-bit slice per stage with a registered carry between slices.
`timescale 1ns/1ps

module pipelined_add_sub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SW = WIDTH / STAGES;

  logic             advance;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             c_r;
  logic             v_r;

  // The whole pipe moves together; it only freezes while a finished result waits.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_r <= 1'b0;
    end else if (advance) begin
      v_r <= in_valid;
    end
  end

  // NOTE: datapath registers carry no reset; their contents are ignored until the
  // matching valid bit, which is reset, marks them as live.
  always_ff @(posedge clk) begin
    if (advance && in_valid) begin
      a_r <= a;
      b_r <= sub ? ~b : b;
      c_r <= sub ? ~cin : cin;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits still to be summed (slice k and above) and the sum built so far.
    localparam int RW = WIDTH - k * SW;

    logic [RW-1:0]       a_d;
    logic [RW-1:0]       b_d;
    logic                c_d;
    logic                v_d;
    logic [SW:0]         slice;
    logic [k*SW+SW-1:0]  s_n;

    if (k == 0) begin : g_src
      assign a_d = a_r;
      assign b_d = b_r;
      assign c_d = c_r;
      assign v_d = v_r;
      assign s_n = slice[SW-1:0];
    end else begin : g_src
      assign a_d = g_stage[k-1].g_mid.a_q;
      assign b_d = g_stage[k-1].g_mid.b_q;
      assign c_d = g_stage[k-1].g_mid.c_q;
      assign v_d = g_stage[k-1].g_mid.v_q;
      assign s_n = {slice[SW-1:0], g_stage[k-1].g_mid.s_q};
    end

    assign slice = {1'b0, a_d[SW-1:0]} + {1'b0, b_d[SW-1:0]} + {{SW{1'b0}}, c_d};

    if (k < STAGES - 1) begin : g_mid
      logic [RW-SW-1:0]   a_q;
      logic [RW-SW-1:0]   b_q;
      logic [k*SW+SW-1:0] s_q;
      logic               c_q;
      logic               v_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_q <= 1'b0;
        end else if (advance) begin
          v_q <= v_d;
        end
      end

      always_ff @(posedge clk) begin
        if (advance && v_d) begin
          a_q <= a_d[RW-1:SW];
          b_q <= b_d[RW-1:SW];
          s_q <= s_n;
          c_q <= slice[SW];
        end
      end
    end else begin : g_last
      // Top slice: its operand MSBs are the word MSBs, so signed overflow is decided here.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_valid <= 1'b0;
          sum       <= '0;
          cout      <= 1'b0;
          ovf       <= 1'b0;
        end else if (advance) begin
          out_valid <= v_d;
          if (v_d) begin
            sum  <= s_n;
            cout <= slice[SW];
            ovf  <= (a_d[SW-1] == b_d[SW-1]) && (slice[SW-1] != a_d[SW-1]);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Scoreboard bench for pipelined_add_sub: the driver queues expected results on
// acceptance, a monitor pops and compares on every output transfer.
`timescale 1ns/1ps

module tb_pipelined_add_sub;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;
    bit          exact;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int   checks    = 0;
  int   failures  = 0;
  int   cycle     = 0;
  int   sink_mode = 0;
  exp_t sb[$];

  pipelined_add_sub #(.WIDTH(16), .STAGES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] s, input logic c, input logic o, input bit ex);
    exp_t e;
    e.sum = s; e.cout = c; e.ovf = o; e.acc = 0; e.exact = ex;
    return e;
  endfunction

  // Reference: plain integer arithmetic, independent of any slicing.
  function automatic exp_t model(input logic [15:0] va, input logic [15:0] vb,
                                 input logic vc, input logic vs);
    exp_t        e;
    logic [16:0] r;
    int          s;
    if (vs) begin
      r = {1'b0, va} - {1'b0, vb} - 17'(vc);
      s = int'($signed(va)) - int'($signed(vb)) - int'(vc);
      e.cout = ~r[16];
    end else begin
      r = {1'b0, va} + {1'b0, vb} + 17'(vc);
      s = int'($signed(va)) + int'($signed(vb)) + int'(vc);
      e.cout = r[16];
    end
    e.sum   = r[15:0];
    e.ovf   = (s > 32767) || (s < -32768);
    e.acc   = 0;
    e.exact = 1'b0;
    return e;
  endfunction

  // Downstream sink; applies its mode 2ns after each rising edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (sink_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic send(input logic [15:0] va, input logic [15:0] vb,
                      input logic vc, input logic vs, input exp_t e);
    int   guard = 0;
    exp_t ex    = e;
    in_valid = 1'b1; a = va; b = vb; cin = vc; sub = vs;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      guard++;
      if (guard > 1000) break;
    end
    if (guard > 1000) begin
      check("in_ready_wait", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      ex.acc = cycle;
      sb.push_back(ex);
      in_valid = 1'b0;
      a = 16'($urandom); b = 16'($urandom);
      cin = 1'($urandom); sub = 1'($urandom);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    cin = 1'($urandom); sub = 1'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int guard = 0;
    while (sb.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check({name, "_drain"}, 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every transfer and checks stability across stalls.
  initial begin
    bit          held = 1'b0;
    logic [17:0] hval = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("hold_valid", 32'(out_valid), 32'd1);
          check("hold_data", 32'({sum, cout, ovf}), 32'(hval));
        end
        held = 1'b0;
        if (out_valid) begin
          if (out_ready) begin
            if (sb.size() == 0) begin
              check("unexpected_out", 32'(out_valid), 32'd0);
            end else begin
              e = sb.pop_front();
              check("sum", 32'(sum), 32'(e.sum));
              check("cout", 32'(cout), 32'(e.cout));
              check("ovf", 32'(ovf), 32'(e.ovf));
              if (e.exact) check("latency", 32'(cycle - e.acc), 32'd4);
            end
          end else begin
            held = 1'b1;
            hval = {sum, cout, ovf};
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          stale;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    logic        rs;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed vectors, back to back, exact latency
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0, 1'b1));
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1, 1'b1));
    send(16'h1234, 16'h4321, 1'b1, 1'b0, mk(16'h5556, 1'b0, 1'b0, 1'b1));
    send(16'h0005, 16'h0007, 1'b0, 1'b1, mk(16'hFFFE, 1'b0, 1'b0, 1'b1));
    send(16'h8000, 16'h0001, 1'b0, 1'b1, mk(16'h7FFF, 1'b1, 1'b1, 1'b1));
    drain("directed");

    // Eight mixed beats with a three-cycle output stall mid-stream
    fork
      begin
        send(16'h0001, 16'h0002, 1'b0, 1'b0, mk(16'h0003, 1'b0, 1'b0, 1'b0));
        send(16'h0010, 16'h0001, 1'b0, 1'b1, mk(16'h000F, 1'b1, 1'b0, 1'b0));
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, mk(16'hFFFF, 1'b1, 1'b0, 1'b0));
        send(16'h0000, 16'h0001, 1'b0, 1'b1, mk(16'hFFFF, 1'b0, 1'b0, 1'b0));
        send(16'h8000, 16'h8000, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b1, 1'b0));
        send(16'h7FFF, 16'hFFFF, 1'b0, 1'b1, mk(16'h8000, 1'b0, 1'b1, 1'b0));
        send(16'h1234, 16'h0234, 1'b1, 1'b1, mk(16'h0FFF, 1'b1, 1'b0, 1'b0));
        send(16'h00FF, 16'h0F01, 1'b0, 1'b0, mk(16'h1000, 1'b0, 1'b0, 1'b0));
      end
      begin
        repeat (6) @(posedge clk);
        sink_mode = 1;
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready", 32'(in_ready), 32'd0);
          check("stall_out_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        sink_mode = 0;
      end
    join
    drain("stall");

    // Reset with three beats in flight
    sink_mode = 1;
    send(16'h1111, 16'h2222, 1'b0, 1'b0, mk(16'h3333, 1'b0, 1'b0, 1'b0));
    send(16'h0F0F, 16'h0101, 1'b0, 1'b0, mk(16'h1010, 1'b0, 1'b0, 1'b0));
    send(16'h4000, 16'h1000, 1'b0, 1'b1, mk(16'h3000, 1'b1, 1'b0, 1'b0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd1);
    check("async_rst_sum", 32'(sum), 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sink_mode = 0;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("post_rst_no_stale", 32'(stale), 32'd0);
    @(posedge clk);
    #1;
    send(16'h00F0, 16'h0F10, 1'b0, 1'b0, mk(16'h1000, 1'b0, 1'b0, 1'b1));
    drain("post_rst");

    // Random traffic with random bubbles and back-pressure
    sink_mode = 2;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
      end else begin
        ra = 16'($urandom); rb = 16'($urandom);
        rc = 1'($urandom);  rs = 1'($urandom);
        send(ra, rb, rc, rs, model(ra, rb, rc, rs));
      end
    end
    sink_mode = 0;
    drain("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
